pipelined_mux: RTL

PIPELINED_MUX -- requirements
Module: pipelined_mux

---
 rtl/pipelined_mux.sv | 105 ++++++++++
 1 files changed

// File: rtl/pipelined_mux.sv
// Two-stage pipelined N:1 multiplexer with valid/ready flow control.
// Stage 1 resolves 4:1 groups, stage 2 picks among the groups; an optional scan counter supplies the selector.
module pipelined_mux #(
  parameter int N_INPUTS = 8,
  parameter int WIDTH    = 1,
  localparam int SW      = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_INPUTS*WIDTH-1:0] input_lines,
  input  logic [SW-1:0]             selector_bits,
  input  logic                      scan_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          output_line,
  output logic [SW-1:0]             out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int NG = N_INPUTS / 4;

  // Handshake: a beat moves on any rising edge where its valid and the
  // consumer's ready are both 1; valid never depends on ready.
  logic             accept;
  logic             s1Load;
  logic             s2Load;
  logic [SW-1:0]    scanCnt;
  logic [SW-1:0]    esel;
  logic [WIDTH-1:0] groupNext [NG];

  logic             s1Valid;
  logic [SW-1:0]    s1Sel;
  logic [WIDTH-1:0] s1Group [NG];

  logic             s2Valid;
  logic [SW-1:0]    s2Sel;
  logic [WIDTH-1:0] s2Data;
  logic [WIDTH-1:0] s2Next;

  assign s2Load   = !s2Valid || out_ready;
  assign s1Load   = !s1Valid || s2Load;
  assign in_ready = reset || s1Load;
  assign accept   = in_valid && in_ready && !reset;
  assign esel     = scan_en ? scanCnt : selector_bits;

  always_comb begin
    for (int g = 0; g < NG; g++) begin
      groupNext[g] = input_lines[(g * 4 + int'(esel[1:0])) * WIDTH +: WIDTH];
    end
  end

  // With only one group there are no upper selector bits to decode.
  generate
    if (NG == 1) begin : gSingleGroup
      assign s2Next = s1Group[0];
    end else begin : gMultiGroup
      assign s2Next = s1Group[s1Sel[SW-1:2]];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scanCnt <= '0;
    end else if (accept && scan_en) begin
      scanCnt <= scanCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1Valid <= 1'b0;
      s1Sel   <= '0;
      for (int g = 0; g < NG; g++) begin
        s1Group[g] <= '0;
      end
    end else if (s1Load) begin
      s1Valid <= accept;
      if (accept) begin
        s1Sel   <= esel;
        s1Group <= groupNext;
      end
    end
  end

  // Data registers only change on a real load so idle outputs stay deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2Valid <= 1'b0;
      s2Sel   <= '0;
      s2Data  <= '0;
    end else if (s2Load) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Sel  <= s1Sel;
        s2Data <= s2Next;
      end
    end
  end

  assign output_line = s2Data;
  assign out_sel     = s2Sel;
  assign out_valid   = s2Valid;

endmodule
